// File: rtl/intr_ctrl_if.sv
// ============================================================================
// Module   : intr_ctrl_if
// Brief    : CPU-side request/acknowledge bundle of the interrupt controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface intr_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             IE;
   logic             IntAck;
   logic             Eret;
   logic             IntR;
   logic [1:0]       IntNo;
   logic [WIDTH-1:0] IntAddr;
   logic [2:0]       Pending;
   logic [2:0]       InService;

   modport master (
      input  IE, IntAck, Eret,
      output IntR, IntNo, IntAddr, Pending, InService
   );

   modport slave (
      output IE, IntAck, Eret,
      input  IntR, IntNo, IntAddr, Pending, InService
   );
endinterface

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
// Module   : intr_ctrl
// Brief    : Three-source prioritised, nesting interrupt controller (C > B > A).
// Revision : 1.0
// ============================================================================
`default_nettype none

module intr_ctrl #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] ADDR_A = WIDTH'(32'h3498),
   parameter logic [WIDTH-1:0] ADDR_B = WIDTH'(32'h3544),
   parameter logic [WIDTH-1:0] ADDR_C = WIDTH'(32'h35f0)
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       IRA,
   input  wire logic       IRB,
   input  wire logic       IRC,
   intr_ctrl_if.master     bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [2:0]       pend_q, pend_d;
   logic [2:0]       insvc_q, insvc_d;
   logic             int_r_q, int_r_d;
   logic [1:0]       int_no_q, int_no_d;
   logic [WIDTH-1:0] int_addr_q, int_addr_d;
   logic             hold_q, hold_d;

   logic [2:0]       w_edge;
   logic [1:0]       w_cur;
   logic [1:0]       w_p;
   logic             w_eligible;

   function automatic logic [1:0] highest(input logic [2:0] v);
      if (v[2])      return 2'd3;
      else if (v[1]) return 2'd2;
      else if (v[0]) return 2'd1;
      else           return 2'd0;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] n);
      case (n)
         2'd1:    return 3'b001;
         2'd2:    return 3'b010;
         2'd3:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] addr_of(input logic [1:0] n);
      case (n)
         2'd1:    return ADDR_A;
         2'd2:    return ADDR_B;
         2'd3:    return ADDR_C;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      s1_d       = {IRC, IRB, IRA};
      s2_d       = s1_q;
      s3_d       = s2_q;
      w_edge     = s2_q & ~s3_q;
      w_cur      = highest(insvc_q);
      w_p        = highest(pend_q);
      w_eligible = bus.IE && (w_p > w_cur);

      state_d    = state_q;
      int_r_d    = int_r_q;
      int_no_d   = int_no_q;
      int_addr_d = int_addr_q;
      pend_d     = pend_q;
      insvc_d    = insvc_q;
      hold_d     = 1'b0;

      // Eret retires the old top level before a same-cycle ack adds a new one.
      if (bus.Eret && (insvc_q != 3'b000)) begin
         insvc_d = insvc_q & ~onehot(w_cur);
         hold_d  = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // hold_q keeps IntR low for a cycle after any InService change.
            if (w_eligible && !hold_q) begin
               state_d    = ST_REQ;
               int_r_d    = 1'b1;
               int_no_d   = w_p;
               int_addr_d = addr_of(w_p);
            end
         end
         ST_REQ: begin
            if (bus.IntAck) begin
               insvc_d    = insvc_d | onehot(int_no_q);
               pend_d     = pend_q & ~onehot(int_no_q);
               hold_d     = 1'b1;
               state_d    = ST_IDLE;
               int_r_d    = 1'b0;
               int_no_d   = 2'd0;
               int_addr_d = '0;
            end else if (!w_eligible) begin
               state_d    = ST_IDLE;
               int_r_d    = 1'b0;
               int_no_d   = 2'd0;
               int_addr_d = '0;
            end else if (w_p > int_no_q) begin
               int_no_d   = w_p;
               int_addr_d = addr_of(w_p);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            int_r_d    = 1'b0;
            int_no_d   = 2'd0;
            int_addr_d = '0;
         end
      endcase

      // A fresh edge beats a same-cycle clear of its pending bit.
      pend_d = pend_d | w_edge;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         s1_q       <= 3'b000;
         s2_q       <= 3'b000;
         s3_q       <= 3'b000;
         pend_q     <= 3'b000;
         insvc_q    <= 3'b000;
         int_r_q    <= 1'b0;
         int_no_q   <= 2'd0;
         int_addr_q <= '0;
         hold_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         pend_q     <= pend_d;
         insvc_q    <= insvc_d;
         int_r_q    <= int_r_d;
         int_no_q   <= int_no_d;
         int_addr_q <= int_addr_d;
         hold_q     <= hold_d;
      end
   end

   assign bus.IntR      = int_r_q;
   assign bus.IntNo     = int_no_q;
   assign bus.IntAddr   = int_addr_q;
   assign bus.Pending   = pend_q;
   assign bus.InService = insvc_q;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
// ============================================================================
// Module   : tb_intr_ctrl
// Brief    : Directed self-checking bench for intr_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_intr_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic IRA = 1'b0;
   logic IRB = 1'b0;
   logic IRC = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   intr_ctrl_if #(.WIDTH(32)) bus ();

   intr_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .IRA (IRA),
      .IRB (IRB),
      .IRC (IRC),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [1:0] no, input logic [31:0] addr);
      chk({tag, ".IntR"},    {31'd0, bus.IntR},  {31'd0, r});
      chk({tag, ".IntNo"},   {30'd0, bus.IntNo}, {30'd0, no});
      chk({tag, ".IntAddr"}, bus.IntAddr,        addr);
   endtask

   // One-cycle pulse on {C,B,A}; returns just after the sampling edge t.
   task automatic pulse(input logic [2:0] m);
      {IRC, IRB, IRA} = m;
      step();
      {IRC, IRB, IRA} = 3'b000;
   endtask

   task automatic ack();
      bus.IntAck = 1'b1;
      step();
      bus.IntAck = 1'b0;
   endtask

   task automatic eret();
      bus.Eret = 1'b1;
      step();
      bus.Eret = 1'b0;
   endtask

   initial begin
      bus.IE     = 1'b0;
      bus.IntAck = 1'b0;
      bus.Eret   = 1'b0;

      // Reset hold with sources toggling
      for (int i = 0; i < 4; i++) begin
         {IRC, IRB, IRA} = 3'(i + 5);
         step();
      end
      chk_req("rst_hold", 1'b0, 2'd0, 32'h0);
      chk("rst_hold.Pending",   {29'd0, bus.Pending},   32'h0);
      chk("rst_hold.InService", {29'd0, bus.InService}, 32'h0);

      // Release with IRB held high: exactly one edge
      {IRC, IRB, IRA} = 3'b010;
      bus.IE = 1'b1;
      rst = 1'b0;
      step(); step(); step();
      chk("rel_t2.IntR",    {31'd0, bus.IntR},    32'h0);
      chk("rel_t2.Pending", {29'd0, bus.Pending}, 32'h2);
      step();
      chk_req("rel_t3", 1'b1, 2'd2, 32'h3544);
      ack();
      chk_req("rel_ack", 1'b0, 2'd0, 32'h0);
      chk("rel_ack.InService", {29'd0, bus.InService}, 32'h2);
      chk("rel_ack.Pending",   {29'd0, bus.Pending},   32'h0);
      IRB = 1'b0;
      step(); step();
      chk("rel_level.IntR", {31'd0, bus.IntR}, 32'h0);
      eret();
      chk("rel_eret.InService", {29'd0, bus.InService}, 32'h0);

      // Single interrupt A
      pulse(3'b001);
      step(); step();
      chk("a_t2.IntR",    {31'd0, bus.IntR},    32'h0);
      chk("a_t2.Pending", {29'd0, bus.Pending}, 32'h1);
      step();
      chk_req("a_t3", 1'b1, 2'd1, 32'h3498);
      ack();
      chk_req("a_ack", 1'b0, 2'd0, 32'h0);
      chk("a_ack.InService", {29'd0, bus.InService}, 32'h1);
      chk("a_ack.Pending",   {29'd0, bus.Pending},   32'h0);

      // Nesting: C interrupts A's handler
      pulse(3'b100);
      step(); step(); step();
      chk_req("nest_c", 1'b1, 2'd3, 32'h35f0);
      ack();
      chk("nest_ack.InService", {29'd0, bus.InService}, 32'h5);
      eret();
      chk("nest_eret1.InService", {29'd0, bus.InService}, 32'h1);
      eret();
      chk("nest_eret2.InService", {29'd0, bus.InService}, 32'h0);
      step(); step();
      chk("nest_idle.IntR", {31'd0, bus.IntR}, 32'h0);

      // Blocking: A pending under B in service
      pulse(3'b010);
      step(); step(); step();
      chk_req("blk_b", 1'b1, 2'd2, 32'h3544);
      ack();
      pulse(3'b001);
      step(); step(); step(); step();
      chk("blk_a.IntR",    {31'd0, bus.IntR},    32'h0);
      chk("blk_a.Pending", {29'd0, bus.Pending}, 32'h1);
      eret();
      chk("blk_k.InService", {29'd0, bus.InService}, 32'h0);
      chk("blk_k.IntR",      {31'd0, bus.IntR},      32'h0);
      step();
      chk("blk_k1.IntR", {31'd0, bus.IntR}, 32'h0);
      step();
      chk_req("blk_k2", 1'b1, 2'd1, 32'h3498);
      ack();
      eret();

      // Simultaneous A and B
      pulse(3'b011);
      step(); step(); step();
      chk_req("sim_b", 1'b1, 2'd2, 32'h3544);
      chk("sim.Pending", {29'd0, bus.Pending}, 32'h3);
      ack();
      chk("sim_ack.InService", {29'd0, bus.InService}, 32'h2);
      chk("sim_ack.Pending",   {29'd0, bus.Pending},   32'h1);
      step(); step(); step();
      chk("sim_blocked.IntR", {31'd0, bus.IntR}, 32'h0);
      eret();
      step(); step();
      chk_req("sim_a", 1'b1, 2'd1, 32'h3498);
      ack();
      eret();

      // Upgrade A -> C without dropping IntR
      pulse(3'b001);
      step(); step(); step();
      chk_req("up_a", 1'b1, 2'd1, 32'h3498);
      pulse(3'b100);
      chk_req("up_t0", 1'b1, 2'd1, 32'h3498);
      step();
      chk_req("up_t1", 1'b1, 2'd1, 32'h3498);
      step();
      chk_req("up_t2", 1'b1, 2'd1, 32'h3498);
      chk("up_t2.Pending", {29'd0, bus.Pending}, 32'h5);
      step();
      chk_req("up_t3", 1'b1, 2'd3, 32'h35f0);
      ack();
      chk("up_ack.InService", {29'd0, bus.InService}, 32'h4);
      chk("up_ack.Pending",   {29'd0, bus.Pending},   32'h1);
      eret();
      step(); step();
      chk_req("up_a_again", 1'b1, 2'd1, 32'h3498);

      // Withdraw on IE low, Pending kept
      bus.IE = 1'b0;
      step();
      chk_req("wd", 1'b0, 2'd0, 32'h0);
      chk("wd.Pending", {29'd0, bus.Pending}, 32'h1);
      step();
      chk("wd2.IntR", {31'd0, bus.IntR}, 32'h0);

      // IntAck in IDLE is ignored
      ack();
      chk("ign.InService", {29'd0, bus.InService}, 32'h0);
      chk("ign.Pending",   {29'd0, bus.Pending},   32'h1);
      chk("ign.IntR",      {31'd0, bus.IntR},      32'h0);
      bus.IE = 1'b1;
      step();
      chk_req("ie_back", 1'b1, 2'd1, 32'h3498);
      ack();
      chk("ie_ack.InService", {29'd0, bus.InService}, 32'h1);
      eret();

      // Mid-operation asynchronous reset in REQ with B in service
      pulse(3'b010);
      step(); step(); step();
      ack();
      pulse(3'b100);
      step(); step(); step();
      chk_req("mid_req", 1'b1, 2'd3, 32'h35f0);
      chk("mid_req.InService", {29'd0, bus.InService}, 32'h2);
      #2 rst = 1'b1;
      #1;
      chk_req("mid_rst", 1'b0, 2'd0, 32'h0);
      chk("mid_rst.Pending",   {29'd0, bus.Pending},   32'h0);
      chk("mid_rst.InService", {29'd0, bus.InService}, 32'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("post_rst.IntR",    {31'd0, bus.IntR},    32'h0);
      chk("post_rst.Pending", {29'd0, bus.Pending}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
